// File: rtl/dice_roll_unit_if.sv
// ----------------------------------------------------------------------------
// dice_roll_unit_if
// Groups the request and result signals of the dice roll unit.
//   roll_req    : request strobe from game logic
//   sides       : number of sides N for the request
//   roll_ready  : consumer ready for the result
//   busy        : unit is working on or holding a roll
//   roll_valid  : result valid, held until roll_ready
//   roll_value  : result 1..N (0 when N==0)
//   roll_biased : result came from the fallback path
// Modports: master = requester/consumer side, slave = dice roll unit side.
// ----------------------------------------------------------------------------
interface dice_roll_unit_if #(
  parameter int WIDTH = 8
);
  logic             roll_req;
  logic [WIDTH-1:0] sides;
  logic             roll_ready;
  logic             busy;
  logic             roll_valid;
  logic [WIDTH-1:0] roll_value;
  logic             roll_biased;

  modport master (
    output roll_req, sides, roll_ready,
    input  busy, roll_valid, roll_value, roll_biased
  );

  modport slave (
    input  roll_req, sides, roll_ready,
    output busy, roll_valid, roll_value, roll_biased
  );
endinterface

// File: rtl/dice_roll_unit.sv
// ----------------------------------------------------------------------------
// dice_roll_unit
// Turns a free-running random byte into an unbiased roll 1..N using
// mask-and-reject sampling. After MAX_TRIES rejected samples a folded
// fallback value is produced and flagged as biased.
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset, aborts any roll
//   random_number : free-running random source, sampled only in SAMPLE
//   bus           : dice_roll_unit_if.slave (request pulse, result handshake)
// Optional feature macro: DICE_NO_REPEAT_EN
//   When defined, a sample equal to the previous handshaked result is
//   rejected (N>1 only, except on the final try).
// ----------------------------------------------------------------------------
module dice_roll_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] random_number,
  dice_roll_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LastTry = 8'(MAX_TRIES - 1);

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_sides, w_sidesNext;
  logic [WIDTH-1:0] r_mask, w_maskNext;
  logic [WIDTH-1:0] r_value, w_valueNext;
  logic             r_biased, w_biasedNext;
  logic [7:0]       r_tries, w_triesNext;

  logic [WIDTH-1:0] w_sidesMinusOne;
  logic [WIDTH-1:0] w_reqMask;
  logic [WIDTH-1:0] w_sample;
  logic [WIDTH-1:0] w_samplePlusOne;
  logic             w_inRange;
  logic             w_lastTry;
  logic             w_accept;

`ifdef DICE_NO_REPEAT_EN
  logic [WIDTH-1:0] r_prev;
`endif

  // Smallest all-ones mask covering N-1: every bit at or below the MSB of
  // N-1 is set, so a masked sample lands in [0, 2N) and acceptance is > 50%.
  always_comb begin
    logic acc;
    acc             = 1'b0;
    w_sidesMinusOne = bus.sides - WIDTH'(1);
    w_reqMask       = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc          = acc | w_sidesMinusOne[i];
      w_reqMask[i] = acc;
    end
  end

  // Sample qualification. With the no-repeat feature, a sample matching the
  // previous result is rejected, but the last try skips that check so a
  // legitimate in-range sample is never folded through the fallback formula.
  always_comb begin
    w_sample        = random_number & r_mask;
    w_samplePlusOne = w_sample + WIDTH'(1);
    w_inRange       = (w_sample < r_sides);
    w_lastTry       = (r_tries == LastTry);
`ifdef DICE_NO_REPEAT_EN
    w_accept = w_inRange &&
               !((r_sides > WIDTH'(1)) && (w_samplePlusOne == r_prev) && !w_lastTry);
`else
    w_accept = w_inRange;
`endif
  end

  // Next-state and datapath decisions for IDLE / SAMPLE / DONE.
  always_comb begin
    w_stateNext  = r_state;
    w_sidesNext  = r_sides;
    w_maskNext   = r_mask;
    w_valueNext  = r_value;
    w_biasedNext = r_biased;
    w_triesNext  = r_tries;
    case (r_state)
      IDLE: begin
        if (bus.roll_req) begin
          w_sidesNext = bus.sides;
          w_maskNext  = w_reqMask;
          w_triesNext = '0;
          if (bus.sides == '0) begin
            w_valueNext  = '0;
            w_biasedNext = 1'b0;
            w_stateNext  = DONE;
          end else begin
            w_stateNext = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (w_accept) begin
          w_valueNext  = w_samplePlusOne;
          w_biasedNext = 1'b0;
          w_stateNext  = DONE;
        end else if (w_lastTry) begin
          w_valueNext  = (w_sample - r_sides) + WIDTH'(1);
          w_biasedNext = 1'b1;
          w_stateNext  = DONE;
        end else begin
          w_triesNext = r_tries + 8'd1;
        end
      end
      DONE: begin
        if (bus.roll_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any roll in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sides  <= '0;
      r_mask   <= '0;
      r_value  <= '0;
      r_biased <= 1'b0;
      r_tries  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_sides  <= w_sidesNext;
      r_mask   <= w_maskNext;
      r_value  <= w_valueNext;
      r_biased <= w_biasedNext;
      r_tries  <= w_triesNext;
    end
  end

`ifdef DICE_NO_REPEAT_EN
  // Remember the last result actually consumed by the game logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else if ((r_state == DONE) && bus.roll_ready) begin
      r_prev <= r_value;
    end
  end
`endif

  // Busy covers everything from acceptance until the handshake completes.
  assign bus.busy        = (r_state != IDLE);
  assign bus.roll_valid  = (r_state == DONE);
  assign bus.roll_value  = r_value;
  assign bus.roll_biased = r_biased;

endmodule

// File: tb/tb_dice_roll_unit.sv
// ----------------------------------------------------------------------------
// tb_dice_roll_unit
// Directed, scoreboard-based bench for dice_roll_unit. Each request pushes
// its hand-computed result into a queue; a monitor pops and compares on
// every completed result handshake.
// ----------------------------------------------------------------------------
module tb_dice_roll_unit;

  localparam int WIDTH     = 8;
  localparam int MAX_TRIES = 8;
  localparam int MaxEdges  = 300;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] random_number;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0]       scoreQ[$];
  logic [WIDTH-1:0] sampleList[$];
  logic [8:0]       monExpected;

  dice_roll_unit_if #(.WIDTH(WIDTH)) bus ();

  dice_roll_unit #(
    .WIDTH     (WIDTH),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .random_number (random_number),
    .bus           (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected summary before it");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: a result is consumed on the edge after a negedge that sees
  // valid and ready both high; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.roll_valid && bus.roll_ready) begin
      compared++;
      if (scoreQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_result: got value %0d biased %0d, expected no result",
                 bus.roll_value, bus.roll_biased);
      end else begin
        monExpected = scoreQ.pop_front();
        if ({bus.roll_biased, bus.roll_value} != monExpected) begin
          mismatched++;
          $display("[TB] FAIL scoreboard: got value %0d biased %0d, expected value %0d biased %0d",
                   bus.roll_value, bus.roll_biased, monExpected[7:0], monExpected[8]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one request, feed queued samples one per edge (the last one is
  // held), and wait with a bound for roll_valid.
  task automatic applyStimulus(input string name, input logic [WIDTH-1:0] sidesIn,
                               input logic [WIDTH-1:0] expValue, input logic expBiased,
                               input int expEdges);
    int edges;
    scoreQ.push_back({expBiased, expValue});
    bus.sides    = sidesIn;
    bus.roll_req = 1'b1;
    tick;
    edges        = 1;
    bus.roll_req = 1'b0;
    checkOutput({name, "_busy"}, int'(bus.busy), 1);
    while (!bus.roll_valid && edges < MaxEdges) begin
      if (sampleList.size() != 0) random_number = sampleList.pop_front();
      tick;
      edges++;
    end
    checkOutput({name, "_latency"}, edges, expEdges);
    checkOutput({name, "_value"}, int'(bus.roll_value), int'(expValue));
    checkOutput({name, "_biased"}, int'(bus.roll_biased), int'(expBiased));
  endtask

  task automatic finishHandshake(input string name);
    tick;
    checkOutput({name, "_valid_drop"}, int'(bus.roll_valid), 0);
    checkOutput({name, "_busy_drop"}, int'(bus.busy), 0);
  endtask

  initial begin
    $display("[TB] dice_roll_unit bench start");

    // Reset held two cycles with a request pending.
    reset          = 1'b1;
    bus.roll_req   = 1'b1;
    bus.sides      = 8'd6;
    bus.roll_ready = 1'b1;
    random_number  = 8'h00;
    tick;
    tick;
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_valid", int'(bus.roll_valid), 0);
    checkOutput("reset_value", int'(bus.roll_value), 0);
    checkOutput("reset_biased", int'(bus.roll_biased), 0);
    reset        = 1'b0;
    bus.roll_req = 1'b0;
    tick;
    checkOutput("post_reset_idle", int'(bus.busy), 0);

    // N=6, s=3 accepted at first sample.
    sampleList.push_back(8'h0B);
    applyStimulus("d6_first", 8'd6, 8'd4, 1'b0, 2);
    finishHandshake("d6_first");

    // N=6, two rejections then s=2.
    sampleList.push_back(8'h07);
    sampleList.push_back(8'h0E);
    sampleList.push_back(8'h02);
    applyStimulus("d6_reject", 8'd6, 8'd3, 1'b0, 4);
    finishHandshake("d6_reject");

    // N=5 with s=7 forever: fallback after MAX_TRIES samples.
    sampleList.push_back(8'h07);
    applyStimulus("d5_fallback", 8'd5, 8'd3, 1'b1, 1 + MAX_TRIES);
    finishHandshake("d5_fallback");

    // N=0: immediate zero result.
    applyStimulus("d0", 8'd0, 8'd0, 1'b0, 1);
    finishHandshake("d0");

    // N=1: mask 0, always 1.
    sampleList.push_back(8'hFF);
    applyStimulus("d1", 8'd1, 8'd1, 1'b0, 2);
    finishHandshake("d1");

    // N=255: top value reachable.
    sampleList.push_back(8'hFE);
    applyStimulus("d255", 8'd255, 8'd255, 1'b0, 2);
    finishHandshake("d255");

    // N=200: s=200 rejected, s=199 gives 200.
    sampleList.push_back(8'hC8);
    sampleList.push_back(8'hC7);
    applyStimulus("d200", 8'd200, 8'd200, 1'b0, 3);
    finishHandshake("d200");

    // Backpressure with an ignored request during the wait.
    bus.roll_ready = 1'b0;
    sampleList.push_back(8'h05);
    applyStimulus("bp", 8'd6, 8'd6, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      bus.roll_req = (i == 2);
      bus.sides    = 8'd3;
      tick;
      checkOutput("bp_hold_valid", int'(bus.roll_valid), 1);
      checkOutput("bp_hold_value", int'(bus.roll_value), 6);
    end
    bus.roll_req   = 1'b0;
    bus.roll_ready = 1'b1;
    finishHandshake("bp");
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("bp_no_second", int'(bus.roll_valid), 0);
    end

    // Reset on the second sample edge aborts the roll.
    bus.sides     = 8'd6;
    bus.roll_req  = 1'b1;
    tick;
    bus.roll_req  = 1'b0;
    random_number = 8'h07;
    tick;
    reset         = 1'b1;
    tick;
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_valid", int'(bus.roll_valid), 0);
    checkOutput("abort_value", int'(bus.roll_value), 0);
    checkOutput("abort_biased", int'(bus.roll_biased), 0);
    reset = 1'b0;
    tick;

    // N=2 after abort, then the same sample again.
    sampleList.push_back(8'h01);
    applyStimulus("d2", 8'd2, 8'd2, 1'b0, 2);
    finishHandshake("d2");
`ifdef DICE_NO_REPEAT_EN
    sampleList.push_back(8'h01);
    sampleList.push_back(8'h00);
    applyStimulus("d2_repeat", 8'd2, 8'd1, 1'b0, 3);
`else
    sampleList.push_back(8'h01);
    applyStimulus("d2_repeat", 8'd2, 8'd2, 1'b0, 2);
`endif
    finishHandshake("d2_repeat");

    tick;
    checkOutput("scoreboard_drained", scoreQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dice_roll_unit.md
Name: dice_roll_unit

Overview:
- Consumes the free-running 8-bit `random_number` from the LFSR stage and turns it into an unbiased game roll in the range 1..N, where N (number of sides) is supplied per request.
- Uses mask-and-reject sampling, with a bounded retry count and a flagged fallback.
- Sits between the random source and game logic (dice, card draw, spawn choice).
- Requests use a pulse interface; the result uses a valid/ready handshake.

Parameters:
- WIDTH, 8: width of `random_number`, `sides` and `roll_value`.
- MAX_TRIES, 8: number of rejected samples before the fallback path is taken. Range 1..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- random_number  input  WIDTH  random source; it changes every cycle.
- roll_req  input  1  request strobe; accepted only when busy==0.
- sides  input  WIDTH  number of sides N; latched on acceptance.
- roll_ready  input  1  consumer ready.
- busy  output  1  high from the acceptance edge until the result handshake completes.
- roll_valid  output  1  result valid; held until roll_ready.
- roll_value  output  WIDTH  result 1..N (0 when N==0).
- roll_biased  output  1  set with roll_valid when the result came from the fallback path.

Behaviour:
- Reset (synchronous): FSM goes to IDLE. busy=0, roll_valid=0, roll_value=0, roll_biased=0. Internal sides/mask/try counter are cleared. Reset in any state, including mid-SAMPLE or mid-DONE, aborts the roll; no result is produced.
- FSM states: IDLE, SAMPLE, DONE.
- IDLE:
  - On an edge with roll_req=1: latch sides -> N.
  - Compute mask = (N-1) with all bits below its MSB smeared to 1. Examples: N=6 -> 7, N=1 -> 0, N=200 -> 255.
  - Clear tries and set busy=1.
  - If N==0: go to DONE with roll_value=0, roll_biased=0, roll_valid=1 after that same edge.
  - Otherwise go to SAMPLE.
- SAMPLE (one sample per edge):
  - s = random_number & mask.
  - If s < N: roll_value = s+1, roll_biased=0, go to DONE.
  - Else, if tries == MAX_TRIES-1: fallback. roll_value = (s-N)+1 (s < 2N is guaranteed), roll_biased=1, go to DONE.
  - Else: tries++ and stay in SAMPLE.
- Latency: minimum 2 edges from request to valid (acceptance edge, then one accepting sample edge). Maximum 1+MAX_TRIES edges.
- DONE:
  - roll_valid=1; roll_value and roll_biased are held stable.
  - On an edge with roll_ready=1: roll_valid=0, busy=0, go to IDLE. roll_value keeps its last value.
- roll_req while busy=1 is ignored, not queued. This includes the DONE handshake edge, so back-to-back rolls have at least one IDLE cycle between them.
- N==1: mask=0, so s=0 and the first sample accepts; value is 1.
- Arithmetic is WIDTH-bit unsigned. s+1 cannot overflow because s < N ≤ 2^WIDTH-1.
- `random_number` is used only in SAMPLE. Its value in IDLE and DONE is don't-care.

Optional Feature:
- Macro: DICE_NO_REPEAT_EN.
- Defined:
  - A previous-result register (prev) is cleared by reset and updated on each completed handshake.
  - In SAMPLE, when N>1, an otherwise-accepted sample with s+1 == prev is treated as a rejection and counts toward tries.
  - The fallback path is exempt from this check.
  - prev is ignored for N==0 and N==1.
- Not defined: no prev register; acceptance is s < N only.

Test Plan:
1. Assert reset 2 cycles, roll_req=1 during reset -> busy, roll_valid, roll_value, roll_biased all 0; FSM in IDLE after release.
2. sides=6, pulse roll_req, random_number=0x0B at the first sample edge (s=3) -> roll_valid=1 after 2nd edge, roll_value=4, roll_biased=0; roll_ready=1 -> valid and busy drop next edge.
3. sides=6, samples 0x07, 0x0E, 0x02 (s=7, 6, 2) -> two rejections, roll_value=3 on the 3rd sample edge, roll_biased=0.
4. MAX_TRIES=8, sides=5, random_number held at 0x07 -> 8 sample edges, then roll_value=3, roll_biased=1; sides=0 -> roll_value=0 one edge after request.
5. Backpressure: roll_ready=0 for 5 cycles while valid -> roll_valid and roll_value stable; roll_req pulsed during wait is ignored (no second result after the handshake).
6. Reset asserted on 2nd SAMPLE edge -> next cycle all outputs 0, IDLE; new request sides=2, sample 0x01 -> roll_value=2. With DICE_NO_REPEAT_EN: repeat the request with sample 0x01 then 0x00 -> first rejected, roll_value=1.
